// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: register index width and the grant encoding.
package wb_pkg;

  localparam int REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_ALU,
    GNT_LD
  } grant_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus between execute/memory stages, decode and the arbiter.
// The master side drives requests and decode indices; the slave side is the arbiter.
interface wb_arbiter_if #(
  parameter int XLEN = 32
);
  import wb_pkg::*;

  logic            alu_valid;
  reg_idx_t        alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;

  logic            ld_issue;
  reg_idx_t        ld_issue_rd;
  logic            ld_issue_ready;

  logic            ld_valid;
  reg_idx_t        ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            ld_ready;

  reg_idx_t        rs1;
  reg_idx_t        rs2;
  reg_idx_t        dec_rd;
  logic            dec_rd_en;
  logic            stall;

  logic            we3;
  reg_idx_t        a3;
  logic [XLEN-1:0] wd3;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_issue, ld_issue_rd,
    output ld_valid, ld_rd, ld_data,
    output rs1, rs2, dec_rd, dec_rd_en,
    input  alu_ready, ld_issue_ready, ld_ready, stall,
    input  we3, a3, wd3
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_issue, ld_issue_rd,
    input  ld_valid, ld_rd, ld_data,
    input  rs1, rs2, dec_rd, dec_rd_en,
    output alu_ready, ld_issue_ready, ld_ready, stall,
    output we3, a3, wd3
  );

endinterface

// File: rtl/wb_arbiter_rr_arb2.sv
// Two-request round-robin arbiter; the grant is combinational and the last
// winner is remembered so that simultaneous requests alternate.
module rr_arb2
  import wb_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   req_alu_i,
  input  logic   req_ld_i,
  output grant_e grant_o
);

  grant_e lastGrant_q;
  grant_e lastGrant_d;

  always_comb begin
    grant_o = GNT_NONE;
    if (req_alu_i && req_ld_i) begin
      grant_o = (lastGrant_q == GNT_ALU) ? GNT_LD : GNT_ALU;
    end else if (req_alu_i) begin
      grant_o = GNT_ALU;
    end else if (req_ld_i) begin
      grant_o = GNT_LD;
    end
  end

  assign lastGrant_d = (grant_o == GNT_NONE) ? lastGrant_q : grant_o;

  // Reset to the load side so the ALU wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lastGrant_q <= GNT_LD;
    end else begin
      lastGrant_q <= lastGrant_d;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter with outstanding-load scoreboard and decode stall.
// Optional feature macro: WB_PERF_EN adds the saturating conflict_cnt output.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int MAX_LD = 4
) (
  input  logic clk,
  input  logic rst,
  wb_arbiter_if.slave bus
`ifdef WB_PERF_EN
  ,
  output logic [31:0] conflict_cnt
`endif
);

  localparam logic [3:0] MaxLd = 4'(MAX_LD);

  grant_e          grant;
  logic            issueAcc;
  logic            pending;

  logic [31:0]     busy_q, busy_d;
  logic [3:0]      ldCnt_q, ldCnt_d;
  logic            we3_q, we3_d;
  reg_idx_t        a3_q, a3_d;
  logic [XLEN-1:0] wd3_q, wd3_d;

  rr_arb2 u_arb (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_alu_i(bus.alu_valid),
    .req_ld_i (bus.ld_valid),
    .grant_o  (grant)
  );

  assign bus.alu_ready      = (grant == GNT_ALU);
  assign bus.ld_ready       = (grant == GNT_LD);
  assign bus.ld_issue_ready = (ldCnt_q != MaxLd);
  assign issueAcc           = bus.ld_issue && bus.ld_issue_ready;

  always_comb begin
    we3_d = 1'b0;
    a3_d  = a3_q;
    wd3_d = wd3_q;
    if (grant == GNT_ALU) begin
      we3_d = (bus.alu_rd != '0);
      a3_d  = bus.alu_rd;
      wd3_d = bus.alu_data;
    end else if (grant == GNT_LD) begin
      we3_d = (bus.ld_rd != '0);
      a3_d  = bus.ld_rd;
      wd3_d = bus.ld_data;
    end
  end

  // Clear before set so an issue and a return to the same register leave it busy.
  always_comb begin
    busy_d = busy_q;
    if (grant == GNT_LD) begin
      busy_d[bus.ld_rd] = 1'b0;
    end
    if (issueAcc && (bus.ld_issue_rd != '0)) begin
      busy_d[bus.ld_issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    ldCnt_d = ldCnt_q;
    if (issueAcc && !(grant == GNT_LD)) begin
      ldCnt_d = ldCnt_q + 4'd1;
    end else if (!issueAcc && (grant == GNT_LD) && (ldCnt_q != 4'd0)) begin
      ldCnt_d = ldCnt_q - 4'd1;
    end
  end

  // No bypass into the register file, so the in-flight write must also stall.
  assign pending = we3_q && (a3_q != '0) &&
                   ((a3_q == bus.rs1) || (a3_q == bus.rs2) ||
                    (bus.dec_rd_en && (a3_q == bus.dec_rd)));

  assign bus.stall = busy_q[bus.rs1] | busy_q[bus.rs2] |
                     (bus.dec_rd_en & busy_q[bus.dec_rd]) | pending;

  assign bus.we3 = we3_q;
  assign bus.a3  = a3_q;
  assign bus.wd3 = wd3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      ldCnt_q <= '0;
      we3_q   <= 1'b0;
      a3_q    <= '0;
      wd3_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      ldCnt_q <= ldCnt_d;
      we3_q   <= we3_d;
      a3_q    <= a3_d;
      wd3_q   <= wd3_d;
    end
  end

`ifdef WB_PERF_EN
  logic [31:0] conflictCnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      conflictCnt_q <= '0;
    end else if (bus.alu_valid && bus.ld_valid && (conflictCnt_q != 32'hFFFF_FFFF)) begin
      conflictCnt_q <= conflictCnt_q + 32'd1;
    end
  end

  assign conflict_cnt = conflictCnt_q;
`endif

  // Protocol checks: ALU must not overwrite a register owned by an outstanding load,
  // and a load return must target a register that is actually outstanding.
  aluBusyWrite: assert property (@(posedge clk) disable iff (rst)
    !((grant == GNT_ALU) && busy_q[bus.alu_rd]));

  ldNotBusy: assert property (@(posedge clk) disable iff (rst)
    !((grant == GNT_LD) && (bus.ld_rd != '0) && !busy_q[bus.ld_rd]));

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized bench for wb_arbiter against a queue-based model of outstanding loads.
// Build with WB_PERF_EN defined to also check the conflict counter.
module tb_wb_arbiter;

  localparam int XLEN   = 32;
  localparam int MAX_LD = 4;

  logic clk;
  logic rst;

  wb_arbiter_if #(.XLEN(XLEN)) bus ();

`ifdef WB_PERF_EN
  logic [31:0] conflictCnt;
`endif

  wb_arbiter #(.XLEN(XLEN), .MAX_LD(MAX_LD)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef WB_PERF_EN
    ,
    .conflict_cnt(conflictCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errorCount = 0;
  int checkCount = 0;

  // Model: outstanding loads are a list of destination registers; busy means "listed".
  int unsigned outQ[$];
  bit          lastWasAlu;
  logic        mWe3;
  logic [4:0]  mA3;
  logic [31:0] mWd3;
  logic [31:0] mConflict;

  // Held requests: a request stays stable until the model says it was granted.
  bit          aluPend, ldPend;
  logic [4:0]  aluRd, ldRd;
  logic [31:0] aluData, ldData;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic bit inQueue(input int unsigned r);
    foreach (outQ[i]) if (outQ[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit isBusy(input int unsigned r);
    return (r != 0) && inQueue(r);
  endfunction

  function automatic logic [4:0] pickSrc();
    int unsigned sel;
    sel = $urandom_range(0, 3);
    if (sel == 0 && outQ.size() > 0) return 5'(outQ[$urandom_range(0, outQ.size() - 1)]);
    if (sel == 1) return mA3;
    return 5'($urandom_range(0, 31));
  endfunction

  task automatic modelReset();
    outQ.delete();
    lastWasAlu = 1'b0;
    mWe3 = 1'b0;
    mA3 = '0;
    mWd3 = '0;
    mConflict = '0;
    aluPend = 1'b0;
    ldPend = 1'b0;
  endtask

  task automatic applyStimulus(input bit doReset);
    int unsigned c;
    rst = doReset;
    bus.ld_issue = 1'b0;
    bus.ld_issue_rd = 5'($urandom_range(0, 31));
    if (doReset) begin
      aluPend = 1'b0;
      ldPend = 1'b0;
    end else begin
      if (!aluPend && $urandom_range(0, 99) < 50) begin
        c = $urandom_range(0, 31);
        for (int k = 0; k < 40 && isBusy(c); k++) c = $urandom_range(0, 31);
        if (isBusy(c)) c = 0;
        aluPend = 1'b1;
        aluRd = 5'(c);
        aluData = $urandom;
      end
      if (!ldPend && outQ.size() > 0 && $urandom_range(0, 99) < 40) begin
        ldPend = 1'b1;
        ldRd = 5'(outQ[$urandom_range(0, outQ.size() - 1)]);
        ldData = $urandom;
      end
      if ($urandom_range(0, 99) < 45) begin
        c = $urandom_range(0, 31);
        if (c == 0 || (!inQueue(c) && !(aluPend && aluRd == 5'(c)))) begin
          bus.ld_issue = 1'b1;
          bus.ld_issue_rd = 5'(c);
        end
      end
    end
    bus.alu_valid = aluPend;
    bus.alu_rd    = aluPend ? aluRd : 5'($urandom_range(0, 31));
    bus.alu_data  = aluPend ? aluData : $urandom;
    bus.ld_valid  = ldPend;
    bus.ld_rd     = ldPend ? ldRd : 5'($urandom_range(0, 31));
    bus.ld_data   = ldPend ? ldData : $urandom;
    bus.rs1       = pickSrc();
    bus.rs2       = pickSrc();
    bus.dec_rd    = pickSrc();
    bus.dec_rd_en = 1'($urandom_range(0, 1));
  endtask

  task automatic runCycle(input bit doReset);
    int  g;
    bit  expStall, issueAcc;
    @(negedge clk);
    applyStimulus(doReset);
    #1;
    if (bus.alu_valid && bus.ld_valid) g = lastWasAlu ? 2 : 1;
    else if (bus.alu_valid) g = 1;
    else if (bus.ld_valid) g = 2;
    else g = 0;

    expStall = isBusy(bus.rs1) || isBusy(bus.rs2) || (bus.dec_rd_en && isBusy(bus.dec_rd)) ||
               (mWe3 && mA3 != 0 && (mA3 == bus.rs1 || mA3 == bus.rs2 ||
                                     (bus.dec_rd_en && mA3 == bus.dec_rd)));
    checkOutput("alu_ready", 32'(bus.alu_ready), 32'(g == 1));
    checkOutput("ld_ready", 32'(bus.ld_ready), 32'(g == 2));
    checkOutput("ld_issue_ready", 32'(bus.ld_issue_ready), 32'(outQ.size() != MAX_LD));
    checkOutput("stall", 32'(bus.stall), 32'(expStall));
    checkOutput("we3", 32'(bus.we3), 32'(mWe3));
    checkOutput("a3", 32'(bus.a3), 32'(mA3));
    checkOutput("wd3", bus.wd3, mWd3);
`ifdef WB_PERF_EN
    checkOutput("conflict_cnt", conflictCnt, mConflict);
`endif

    if (doReset) begin
      modelReset();
    end else begin
      issueAcc = bus.ld_issue && (outQ.size() != MAX_LD);
      if (bus.alu_valid && bus.ld_valid && mConflict != 32'hFFFF_FFFF) mConflict++;
      mWe3 = 1'b0;
      if (g == 1) begin
        mWe3 = (aluRd != 0);
        mA3 = aluRd;
        mWd3 = aluData;
        lastWasAlu = 1'b1;
        aluPend = 1'b0;
      end else if (g == 2) begin
        mWe3 = (ldRd != 0);
        mA3 = ldRd;
        mWd3 = ldData;
        lastWasAlu = 1'b0;
        ldPend = 1'b0;
        for (int i = 0; i < outQ.size(); i++) begin
          if (outQ[i] == 32'(ldRd)) begin
            outQ.delete(i);
            break;
          end
        end
      end
      if (issueAcc) outQ.push_back(32'(bus.ld_issue_rd));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.ld_issue = 1'b0;  bus.ld_issue_rd = '0;
    bus.ld_valid = 1'b0;  bus.ld_rd = '0;  bus.ld_data = '0;
    bus.rs1 = '0; bus.rs2 = '0; bus.dec_rd = '0; bus.dec_rd_en = 1'b0;
    repeat (2) @(posedge clk);
    modelReset();
    runCycle(1'b1);

    // First ALU writeback after reset, then a discarded x0 write.
    aluPend = 1'b1; aluRd = 5'd5; aluData = 32'h0000_00AA;
    runCycle(1'b0);
    aluPend = 1'b1; aluRd = 5'd0; aluData = 32'hFFFF_FFFF;
    runCycle(1'b0);
    runCycle(1'b0);

    for (int n = 0; n < 1500; n++) begin
      runCycle($urandom_range(0, 99) < 2);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Owns the single register-file write port (A3/WD3/WE3) and shares it between two writeback sources: the ALU result path and the variable-latency load-return path.
- Keeps a per-register busy scoreboard for outstanding loads and raises a decode stall on RAW/WAW hazards against those registers.
- Sits between the execute/memory stages and reg_file; decode reads its stall output.

Parameters:
- XLEN, 32, data width of the writeback buses and of wd3.
- MAX_LD, 4, maximum outstanding loads; range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU writeback request.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- alu_ready  out  1  ALU request accepted this cycle.
- ld_issue  in  1  load dispatched to memory this cycle.
- ld_issue_rd  in  5  destination register of the dispatched load.
- ld_issue_ready  out  1  a new load may be dispatched.
- ld_valid  in  1  load data return request.
- ld_rd  in  5  load return destination register.
- ld_data  in  XLEN  load return data.
- ld_ready  out  1  load return accepted this cycle.
- rs1, rs2  in  5  decode source registers.
- dec_rd  in  5  decode destination register.
- dec_rd_en  in  1  dec_rd is valid.
- stall  out  1  decode must hold.
- we3  out  1  register-file write enable.
- a3  out  5  register-file write address.
- wd3  out  XLEN  register-file write data.

Behaviour:
- Reset (rst=1 at a clock edge):
  - busy[31:0]=0, ld_cnt=0, last_grant=GNT_LD (so the ALU wins the first tie).
  - we3=0, a3=0, wd3=0; the registered stage is cleared.
- Arbitration (combinational, same cycle):
  - Only ld_valid: load granted.
  - Only alu_valid: ALU granted.
  - Both valid: round-robin; the source not granted last time wins.
  - No request: no grant, last_grant unchanged.
  - alu_ready and ld_ready are high only for the granted source. A request held without ready must stay stable until accepted.
- Write stage (registered, latency 1):
  - On grant, we3/a3/wd3 are loaded next edge from the winner.
  - A grant with rd=0 is still accepted (ready high), but sets we3=0.
  - No grant: we3=0; a3/wd3 hold their previous values.
- Scoreboard:
  - ld_issue && ld_issue_ready && ld_issue_rd!=0 sets busy[ld_issue_rd] next edge.
  - A load grant clears busy[ld_rd] next edge, i.e. the edge at which we3 is registered.
  - Set and clear of the same index in one cycle: set wins.
- Outstanding-load counter:
  - ld_cnt increments on an accepted issue and decrements on a load grant; both in one cycle leaves it unchanged.
  - ld_issue_ready = (ld_cnt != MAX_LD).
  - ld_issue while not ready is ignored.
  - rd=0 loads still count.
- Stall: stall = busy[rs1] | busy[rs2] | (dec_rd_en & busy[dec_rd]) | pending.
  - pending = we3 and a3 equal to rs1, rs2, or dec_rd (with dec_rd_en); nonzero index only.
  - The register file writes on the edge after we3 is registered, and no bypass exists, so pending is required.
  - busy[0] is never set; x0 never stalls.
- Illegal cases:
  - ALU grant to a busy rd, or a load grant whose rd is not busy, is a protocol error.
  - Flagged by a simulation assertion only; behaviour is otherwise as specified.
- rst mid-operation drops all in-flight state; no write occurs on the following edge.

Optional Feature:
- Macro: WB_PERF_EN.
- Defined: adds output conflict_cnt[31:0].
  - Increments on each cycle with alu_valid && ld_valid, saturating at 0xFFFFFFFF.
  - Cleared by rst.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package wb_pkg holds:
  - REG_AW=5.
  - Typedef reg_idx_t (logic [4:0]).
  - Enum grant_e {GNT_NONE, GNT_ALU, GNT_LD}.
- One sub-module rr_arb2: two-request round-robin arbiter that owns last_grant and outputs grant_e.

Test Plan:
- After reset, alu_valid=1, alu_rd=5, alu_data=0x0000_00AA -> alu_ready=1 that cycle; next cycle we3=1, a3=5, wd3=0xAA.
- ld_issue, ld_issue_rd=7; then rs1=7 -> stall=1 until the ld_valid (rd=7, data 0x1234) grant. Stall remains while we3=1/a3=7, and drops the cycle after.
- alu_valid and ld_valid both held 4 cycles -> grants alternate ALU, LD, ALU, LD; the non-granted ready is 0 each cycle.
- Issue 4 loads with MAX_LD=4 -> ld_issue_ready=0; a 5th ld_issue is ignored (ld_cnt stays 4). One return restores ready=1.
- alu_rd=0 with data 0xFFFF_FFFF -> alu_ready=1 and we3=0 next cycle. A load with rd=0 never sets busy; rs1=0 never stalls.
- rst asserted with busy[3]=1, ld_cnt=2 and we3=1 -> next cycle busy=0, ld_cnt=0, we3=0, stall=0.
